// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode, ALU code, branch condition and FSM state encodings for the CPU control unit.
package cpu_pkg;
  localparam logic [3:0] OP_LD = 4'hA;
  localparam logic [3:0] OP_ST = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_BR = 4'hD;
  localparam logic [3:0] OP_JR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] ALU_PASS_S = 4'hA;
  localparam logic [3:0] ALU_PASS_R = 4'hB;
  localparam logic [1:0] COND_Z = 2'b00;
  localparam logic [1:0] COND_N = 2'b01;
  localparam logic [1:0] COND_C = 2'b10;
  localparam logic [1:0] COND_AL = 2'b11;
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_ALU,
    S_LOAD,
    S_STORE,
    S_JUMP,
    S_HALT
  } state_t;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode/condition decode giving the state that follows DECODE.
import cpu_pkg::*;
module cu_decode (
  input  logic [3:0] op_i,
  input  logic [1:0] cond_i,
  input  logic       c_i,
  input  logic       n_i,
  input  logic       z_i,
  output state_t     next_o
);
  logic taken;
  always_comb begin
    taken = (cond_i == COND_Z) ? z_i :
            (cond_i == COND_N) ? n_i :
            (cond_i == COND_C) ? c_i : 1'b1;
    next_o = (op_i <= 4'h9) ? S_EXEC_ALU :
             (op_i == OP_LD) ? S_LOAD :
             (op_i == OP_ST) ? S_STORE :
             (op_i == OP_HLT) ? S_HALT :
             (op_i == OP_BR && !taken) ? S_FETCH : S_JUMP;
  end
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle FSM driving the execution unit strobes and memory enables.
// Optional memory wait states are enabled by defining CU_WAIT_STATE_EN.
import cpu_pkg::*;
module cpu_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR_out,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_rdy,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic [3:0]  Alu_Op,
  output logic        adr_sel,
  output logic        s_sel,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_sel,
  output logic        reg_w_en,
  output logic        ir_ld,
  output logic        mem_re,
  output logic        mem_we,
  output logic        halted
);
  state_t state_q, state_d, dec_next;
  logic [3:0] op;
  logic rdy;
  assign op = IR_out[15:12];
  assign W_Adr = IR_out[11:9];
  assign R_Adr = IR_out[8:6];
  assign S_Adr = IR_out[5:3];
`ifdef CU_WAIT_STATE_EN
  assign rdy = mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
  assign rdy = 1'b1;
`endif
  cu_decode u_dec (
    .op_i  (op),
    .cond_i(IR_out[9:8]),
    .c_i   (C),
    .n_i   (N),
    .z_i   (Z),
    .next_o(dec_next)
  );
  always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dec_next;
      S_LOAD, S_STORE: state_d = rdy ? S_FETCH : state_q;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end
  // Strobes are forced low while reset is high so an aborted LOAD never writes back.
  always_comb begin
    Alu_Op = 4'h0;
    adr_sel = 1'b0;
    s_sel = 1'b0;
    pc_ld = 1'b0;
    pc_inc = 1'b0;
    pc_sel = 1'b0;
    reg_w_en = 1'b0;
    ir_ld = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    halted = 1'b0;
    if (!reset)
      case (state_q)
        S_FETCH: begin
          mem_re = 1'b1;
          ir_ld = rdy;
          pc_inc = rdy;
        end
        S_EXEC_ALU: begin
          reg_w_en = 1'b1;
          Alu_Op = op;
        end
        S_LOAD: begin
          adr_sel = 1'b1;
          mem_re = 1'b1;
          s_sel = 1'b1;
          Alu_Op = ALU_PASS_S;
          reg_w_en = rdy;
        end
        S_STORE: begin
          adr_sel = 1'b1;
          mem_we = 1'b1;
          Alu_Op = ALU_PASS_S;
        end
        S_JUMP: begin
          pc_ld = 1'b1;
          pc_sel = op == OP_JR;
          Alu_Op = (op == OP_JR) ? ALU_PASS_R : 4'h0;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
  end
endmodule
